// File: rtl/imm_extend_pipe.sv
// Pipelined RISC-V immediate extension with a valid/ready skid buffer (OUT + SKID).
// Optional illegal-select counter on err_cnt is built when IMM_ERR_CNT_EN is defined.
module imm_extend_pipe #(
  parameter int XLEN = 32,
  parameter int TAGW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     inst,
  input  logic [2:0]      immsrc,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [TAGW-1:0] out_tag,
  output logic            out_illegal,
  output logic [15:0]     err_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [TAGW-1:0] tag;
    logic            ill;
  } beat_t;

  // ib[k] holds instruction bit k+7; every field starts as a sign fill from inst[31]
  function automatic logic [XLEN-1:0] imm_decode(input logic [24:0] ib, input logic [2:0] sel);
    logic [XLEN-1:0] r;
    r = {XLEN{ib[24]}};
    case (sel)
      3'b000: r[11:0] = ib[24:13];
      3'b001: r[11:0] = {ib[24:18], ib[4:0]};
      3'b010: r[12:0] = {ib[24], ib[0], ib[23:18], ib[4:1], 1'b0};
      3'b011: r[20:0] = {ib[24], ib[12:5], ib[13], ib[23:14], 1'b0};
      3'b100: r[31:0] = {ib[24:5], 12'h000};
      3'b101: begin
        r      = {XLEN{1'b0}};
        r[4:0] = ib[12:8];
      end
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  beat_t in_beat_s;
  beat_t out_r;
  beat_t skid_r;
  logic  out_v_r;
  logic  skid_v_r;
  logic  accept_s;

  // decode the incoming beat
  always_comb begin
    in_beat_s     = '0;
    in_beat_s.imm = imm_decode(inst, immsrc);
    in_beat_s.tag = in_tag;
    in_beat_s.ill = immsrc[2] & immsrc[1];
  end

  assign accept_s    = in_valid & ~skid_v_r;
  assign in_ready    = ~skid_v_r;
  assign out_valid   = out_v_r;
  assign imm         = out_r.imm;
  assign out_tag     = out_r.tag;
  assign out_illegal = out_r.ill;

  // OUT/SKID occupancy; SKID only fills while OUT is stalled, so order stays FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r    <= '0;
      skid_r   <= '0;
      out_v_r  <= 1'b0;
      skid_v_r <= 1'b0;
    end else if (skid_v_r) begin
      if (out_ready) begin
        out_r    <= skid_r;
        skid_v_r <= 1'b0;
      end else begin
        skid_v_r <= 1'b1;
      end
    end else if (!out_v_r || out_ready) begin
      if (accept_s) begin
        out_r   <= in_beat_s;
        out_v_r <= 1'b1;
      end else begin
        out_v_r <= 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_r   <= in_beat_s;
        skid_v_r <= 1'b1;
      end else begin
        skid_v_r <= 1'b0;
      end
    end
  end

`ifdef IMM_ERR_CNT_EN
  logic [15:0] err_cnt_r;

  // saturating count of accepted illegal beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 16'h0000;
    end else if (accept_s && in_beat_s.ill && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: an XLEN=32 and an XLEN=64 instance share stimulus.
module tb_imm_extend_pipe;

`ifdef IMM_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready64;
  logic [24:0] inst;
  logic [2:0]  immsrc;
  logic [7:0]  in_tag;
  logic        out_valid, out_valid64;
  logic        out_ready;
  logic [31:0] imm;
  logic [63:0] imm64;
  logic [7:0]  out_tag, out_tag64;
  logic        out_illegal, out_illegal64;
  logic [15:0] err_cnt, err_cnt64;

  imm_extend_pipe #(.XLEN(32), .TAGW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .imm(imm), .out_tag(out_tag),
    .out_illegal(out_illegal), .err_cnt(err_cnt)
  );

  imm_extend_pipe #(.XLEN(64), .TAGW(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .inst(inst), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .imm(imm64), .out_tag(out_tag64),
    .out_illegal(out_illegal64), .err_cnt(err_cnt64)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] e32;
    logic [63:0] e64;
    logic [7:0]  tag;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_err = 16'h0000;

  // reference decode written against full 32-bit instruction positions
  function automatic logic [63:0] model(input logic [31:0] ins, input logic [2:0] sel, input int xlen);
    logic [63:0] v;
    case (sel)
      3'd0: v = {{52{ins[31]}}, ins[31:20]};
      3'd1: v = {{52{ins[31]}}, ins[31:25], ins[11:7]};
      3'd2: v = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3: v = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'd4: v = {{32{ins[31]}}, ins[31:12], 12'h000};
      3'd5: v = {59'd0, ins[19:15]};
      default: v = 64'd0;
    endcase
    if (xlen == 32) v[63:32] = 32'd0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [2:0] sel, input logic [7:0] tag);
    in_valid = 1'b1;
    inst     = ins[31:7];
    immsrc   = sel;
    in_tag   = tag;
    cur.e32  = model(ins, sel, 32);
    cur.e64  = model(ins, sel, 64);
    cur.tag  = tag;
    cur.ill  = sel[2] & sel[1];
  endtask

  // one cycle: check outputs against the scoreboard at negedge, then advance
  task automatic step(output bit acc);
    bit drn;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid64", out_valid64, q.size() != 0);
    if (out_valid && q.size() != 0) begin
      chk("imm32", imm, q[0].e32);
      chk("imm64", imm64, q[0].e64);
      chk("out_tag", out_tag, q[0].tag);
      chk("out_illegal", out_illegal, q[0].ill);
      chk("out_tag64", out_tag64, q[0].tag);
    end
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn && q.size() != 0) void'(q.pop_front());
    if (acc) begin
      q.push_back(cur);
      if (ERR_EN && cur.ill && exp_err != 16'hFFFF) exp_err = exp_err + 16'h0001;
    end
    @(posedge clk);
    @(negedge clk);
    chk("err_cnt", err_cnt, exp_err);
  endtask

  task automatic idle_steps(input int n);
    bit a;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step(a);
  endtask

  initial begin
    bit a;
    int t;
    rst_n = 1'b0; in_valid = 1'b0; inst = 25'd0; immsrc = 3'd0; in_tag = 8'd0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_tag", out_tag, 8'd0);
    chk("rst_illegal", out_illegal, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_err_cnt", err_cnt, 16'd0);
    rst_n = 1'b1;

    // directed decode vectors
    drive(32'hFFF00093, 3'b000, 8'h10); cur.e32 = 64'hFFFFFFFF; step(a);
    drive(32'hFE000EE3, 3'b010, 8'h11); cur.e32 = 64'hFFFFFFFC; step(a);
    drive(32'h800000B7, 3'b100, 8'h12); cur.e64 = 64'hFFFFFFFF80000000; step(a);
    drive(32'h000FD073, 3'b101, 8'h13); cur.e64 = 64'h1F; cur.e32 = 64'h1F; step(a);
    drive(32'hFE1FF0A3, 3'b001, 8'h14); step(a);
    drive(32'h8000006F, 3'b011, 8'h15); step(a);
    drive(32'h7FFFF06F, 3'b011, 8'h16); step(a);
    idle_steps(2);

    // backpressure: out_ready low for three cycles after the first accept
    t = 1;
    for (int c = 0; c < 12; c++) begin
      out_ready = !(c >= 1 && c <= 3);
      if (t <= 4) drive({$urandom} | 32'h0000_0080, 3'(t % 4), 8'(t));
      else in_valid = 1'b0;
      step(a);
      if (a) t++;
    end
    out_ready = 1'b1;

    // illegal selects
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 3'b111, 8'h20 + 8'(i));
      step(a);
    end
    idle_steps(2);

    // random traffic with random backpressure
    for (int c = 0; c < 60; c++) begin
      out_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 3) != 0) drive($urandom, 3'($urandom_range(0, 7)), 8'($urandom));
      else in_valid = 1'b0;
      step(a);
    end
    out_ready = 1'b1;
    idle_steps(3);

    // reset mid-stream with OUT and SKID full
    out_ready = 1'b0;
    drive(32'h12345093, 3'b000, 8'h31); step(a);
    drive(32'h23456093, 3'b000, 8'h32); step(a);
    chk("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_imm", imm, 32'd0);
    chk("arst_err_cnt", err_cnt, 16'd0);
    q.delete();
    exp_err = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(32'hABCDE0B7, 3'b100, 8'h40); step(a);
    idle_steps(2);

`ifdef IMM_ERR_CNT_EN
    // counter saturation
    for (int i = 0; i < 65537; i++) begin
      drive($urandom, 3'b110, 8'(i));
      step(a);
    end
    idle_steps(2);
    chk("err_cnt_sat", err_cnt, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
